// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_sub.sv
// One-bit full subtractor cell: computes x - y - z.
// Ports:
//   x  minuend bit
//   y  subtrahend bit
//   z  borrow in
//   D  difference bit
//   B  borrow out
module full_sub (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic D,
  output logic B
);

  assign D = x ^ y ^ z;
  assign B = (~x & y) | (~x & z) | (y & z);

endmodule : full_sub

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
// clock, LSB first, with a final borrow flag.
// Optional feature: define SERIAL_SUB_OVF_EN to add a signed-overflow output.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a subtraction (accepted only in IDLE)
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while bits are being processed
//   done        one-cycle pulse when diff / borrow_out are updated
//   diff        result a - b, held until the next completion
//   borrow_out  1 when unsigned a < b
//   ovf         (SERIAL_SUB_OVF_EN only) signed two's-complement overflow
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_a_sr,   w_a_sr_nxt;
  logic [WIDTH-1:0] r_b_sr,   w_b_sr_nxt;
  logic [WIDTH-1:0] r_res,    w_res_nxt;
  logic [WIDTH-1:0] r_diff,   w_diff_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_borrow, w_borrow_nxt;
  logic             r_bout,   w_bout_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             w_d;
  logic             w_b;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb,  w_a_msb_nxt;
  logic             r_b_msb,  w_b_msb_nxt;
  logic             r_ovf,    w_ovf_nxt;
`endif

  // Per-bit arithmetic on the current LSBs and the carried borrow
  full_sub u_full_sub (
    .x (r_a_sr[0]),
    .y (r_b_sr[0]),
    .z (r_borrow),
    .D (w_d),
    .B (w_b)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_a_sr   <= w_a_sr_nxt;
      r_b_sr   <= w_b_sr_nxt;
      r_res    <= w_res_nxt;
      r_diff   <= w_diff_nxt;
      r_cnt    <= w_cnt_nxt;
      r_borrow <= w_borrow_nxt;
      r_bout   <= w_bout_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= w_a_msb_nxt;
      r_b_msb  <= w_b_msb_nxt;
      r_ovf    <= w_ovf_nxt;
`endif
    end
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt  = r_state;
    w_a_sr_nxt   = r_a_sr;
    w_b_sr_nxt   = r_b_sr;
    w_res_nxt    = r_res;
    w_diff_nxt   = r_diff;
    w_cnt_nxt    = r_cnt;
    w_borrow_nxt = r_borrow;
    w_bout_nxt   = r_bout;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    w_a_msb_nxt  = r_a_msb;
    w_b_msb_nxt  = r_b_msb;
    w_ovf_nxt    = r_ovf;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_sr_nxt   = a;
          w_b_sr_nxt   = b;
          w_borrow_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          w_a_msb_nxt  = a[WIDTH-1];
          w_b_msb_nxt  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        // Difference bits enter from the MSB side so that after WIDTH steps
        // the first (LSB) result bit has reached bit 0.
        w_res_nxt    = {w_d, r_res[WIDTH-1:1]};
        w_a_sr_nxt   = r_a_sr >> 1;
        w_b_sr_nxt   = r_b_sr >> 1;
        w_borrow_nxt = w_b;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_diff_nxt  = w_res_nxt;
          w_bout_nxt  = w_b;
`ifdef SERIAL_SUB_OVF_EN
          // The last difference bit produced is the result MSB
          w_ovf_nxt   = (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = r_ovf;
`endif

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH = 8). A driver issues operations
// and pushes arithmetic expectations into a queue; a monitor pops one entry
// per done pulse and also checks that results hold between completions.
module tb_serial_sub;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  bit           mon_en = 1'b0;
  exp_t         q[$];
  logic [W-1:0] last_d  = '0;
  logic         last_bo = 1'b0;
  logic         last_ov = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input int unsigned av, input int unsigned bv, input int due);
    exp_t e;
    int   sa;
    int   sb;
    int   sd;
    e.d  = W'((int'(av) - int'(bv)) & ((1 << W) - 1));
    e.bo = (av < bv);
    sa   = (av >= (1 << (W - 1))) ? int'(av) - (1 << W) : int'(av);
    sb   = (bv >= (1 << (W - 1))) ? int'(bv) - (1 << W) : int'(bv);
    sd   = sa - sb;
    e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    e.due = due;
    return e;
  endfunction

  // Monitor: result checks at done, hold checks otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done with diff=0x%0h, expected no pending op", diff);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("borrow_out", int'(borrow_out), int'(e.bo));
          chk("latency_cycle", cyc, e.due);
          chk("busy_at_done", int'(busy), 0);
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", int'(ovf), int'(e.ov));
          last_ov = e.ov;
`endif
          last_d  = e.d;
          last_bo = e.bo;
        end
      end else begin
        chk("diff_hold", int'(diff), int'(last_d));
        chk("borrow_hold", int'(borrow_out), int'(last_bo));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_hold", int'(ovf), int'(last_ov));
`endif
      end
    end
  end

  // Wait for IDLE, present one start for one edge, log the expectation
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b done=%0b, expected idle", busy, done);
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    q.push_back(model(int'(av), int'(bv), cyc + 1 + int'(W)));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Let the operation finish while optionally scrambling inputs and start
  task automatic ride(input bit noise);
    for (int k = 0; k < int'(W) + 4 && busy; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      start = noise ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=%0b, expected 0", busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_borrow", int'(borrow_out), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors
    issue(8'h05, 8'h03); ride(1'b0);
    issue(8'h03, 8'h05); ride(1'b0);
    issue(8'h00, 8'hFF); ride(1'b0);
    issue(8'h80, 8'h01); ride(1'b0);

    // Start pulse with new operands mid-operation must be ignored
    issue(8'h10, 8'h01);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(negedge clk);
    start = 1'b0;
    ride(1'b0);

    // Reset mid-operation: outputs clear at once, no done afterwards
    issue(8'h10, 8'h01);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_borrow", int'(borrow_out), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("midrst_ovf", int'(ovf), 0);
`endif
    q.delete();
    last_d  = '0;
    last_bo = 1'b0;
    last_ov = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    issue(8'h20, 8'h10); ride(1'b0);

    // Random operations, back-to-back, with input and start noise in flight
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom));
      ride(1'b1);
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_sub

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse; diff and borrow_out are valid.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 when unsigned a < b.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at an edge:
- load a and b into shift registers;
- clear the borrow register and the bit counter;
- set busy=1 and enter SHIFT.
REQ-013 Each SHIFT edge SHALL:
- form a one-bit full subtraction of a_sr[0] - b_sr[0] - borrow_reg;
- shift the difference bit into the result register from the MSB side;
- shift a_sr and b_sr right by one;
- set borrow_reg to the stage borrow;
- increment the counter.
REQ-014 Full-subtraction truth: D = x^y^z; B = (~x&y) | (~x&z) | (y&z).
REQ-015 After exactly WIDTH SHIFT edges the FSM SHALL enter DONE with busy=0 and done=1.
REQ-016 diff and borrow_out SHALL update on that same edge.
REQ-017 From DONE the FSM SHALL return to IDLE on the next edge and drop done to 0.
REQ-018 Latency: start accepted at edge E -> done high in the cycle after edge E+WIDTH, for exactly one cycle.
REQ-019 start SHALL be ignored in SHIFT and DONE; the in-flight operation continues unaltered.
REQ-020 diff and borrow_out SHALL hold their last value until the next DONE entry.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-022 Back-to-back starts: start held high SHALL be accepted again in the first IDLE cycle after DONE.

Reset
REQ-023 rst_n low SHALL immediately force IDLE and zero the following: busy, done, diff, borrow_out, shift registers, borrow_reg and counter.
REQ-024 Reset mid-operation SHALL abandon the operation with no done pulse; the next accepted start SHALL compute correctly.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN, when defined, SHALL add output ovf (1 bit) with the following behaviour:
- set at DONE entry to signed two's-complement overflow: (a_msb != b_msb) && (diff_msb != a_msb);
- uses the MSBs captured at start;
- resets to 0 and holds like diff.
REQ-026 Without SERIAL_SUB_OVF_EN, port ovf and its capture registers SHALL NOT exist; all other behaviour is identical.

Structure
REQ-027 Shared package serial_sub_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-028 The per-bit arithmetic SHALL be an instance of the team's existing full_sub cell (ports x, y, z, D, B); no other sub-modules.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, start pulse -> done exactly 9 cycles after the accepting edge, diff=0x02, borrow_out=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
REQ-031 a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-032 a=0x80, b=0x01 (SERIAL_SUB_OVF_EN) -> diff=0x7F, borrow_out=0, ovf=1.
REQ-033 a=0x80, b=0x01 (SERIAL_SUB_OVF_EN off) -> no ovf port; diff=0x7F, borrow_out=0.
REQ-034 Start a=0x10, b=0x01; at cycle 3 pulse start with a=0xFF, b=0x00 -> ignored, one done, diff=0x0F.
REQ-035 Start a=0x10, b=0x01; at cycle 4 assert rst_n=0 -> all outputs 0 immediately, no done.
REQ-036 Same case as REQ-035: release reset, start a=0x20, b=0x10 -> diff=0x10, borrow_out=0.
